// File: rtl/mpu_entry_calc_if.sv
// Front-panel bundle of the entry calculator: switches and raw buttons in,
// ALU result, status flags, LEDs and the two 7-segment digits out.
interface mpu_entry_calc_if #(
   parameter int NIB_W    = 4,
   parameter int OPD_NIBS = 2
);
   localparam int W     = NIB_W * OPD_NIBS;
   localparam int IDX_W = $clog2(1 + 2 * OPD_NIBS);

   logic [NIB_W-1:0] sw;
   logic             btn_enter;
   logic             btn_back;
   logic [2*W-1:0]   result;
   logic             result_valid;
   logic             flag;
   logic             err;
   logic [IDX_W-1:0] entry_idx;
   logic [3:0]       led;
   logic [6:0]       seg_hi;
   logic [6:0]       seg_lo;

   modport master (
      output sw, btn_enter, btn_back,
      input  result, result_valid, flag, err, entry_idx, led, seg_hi, seg_lo
   );

   modport slave (
      input  sw, btn_enter, btn_back,
      output result, result_valid, flag, err, entry_idx, led, seg_hi, seg_lo
   );
endinterface

// File: rtl/mpu_entry_calc.sv
// Nibble-entry calculator: opcode + two multi-nibble operands keyed in with an
// enter/back button pair, single-cycle ALU, LED status and two hex digits.
module mpu_entry_calc #(
   parameter int NIB_W    = 4,
   parameter int OPD_NIBS = 2,
   parameter int SYNC_STG = 2
) (
   input  logic               clk,
   input  logic               rst,
   mpu_entry_calc_if.slave    bus
);
   localparam int W     = NIB_W * OPD_NIBS;
   localparam int N     = 1 + 2 * OPD_NIBS;
   localparam int IDX_W = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENTRY,
      S_CALC,
      S_DONE
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [NIB_W-1:0] entries [N];
   logic [2*W-1:0]   result;
   logic             flag;
   logic             err;
   logic             result_valid;

   logic [SYNC_STG-1:0] en_sync;
   logic [SYNC_STG-1:0] bk_sync;
   logic                en_prev;
   logic                bk_prev;
   logic                enp;
   logic                bkp;

   // The extra prev flop turns the synchronised level into a one-cycle pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_sync <= '0;
         bk_sync <= '0;
         en_prev <= 1'b0;
         bk_prev <= 1'b0;
      end else begin
         en_sync <= {en_sync[SYNC_STG-2:0], bus.btn_enter};
         bk_sync <= {bk_sync[SYNC_STG-2:0], bus.btn_back};
         en_prev <= en_sync[SYNC_STG-1];
         bk_prev <= bk_sync[SYNC_STG-1];
      end
   end

   assign enp = en_sync[SYNC_STG-1] & ~en_prev;
   assign bkp = bk_sync[SYNC_STG-1] & ~bk_prev;

   logic [NIB_W-1:0] opcode;
   logic [W-1:0]     opd_a;
   logic [W-1:0]     opd_b;

   always_comb begin
      opcode = entries[0];
      opd_a  = '0;
      opd_b  = '0;
      for (int i = 0; i < OPD_NIBS; i++) begin
         opd_a[(OPD_NIBS-1-i)*NIB_W +: NIB_W] = entries[1 + i];
         opd_b[(OPD_NIBS-1-i)*NIB_W +: NIB_W] = entries[1 + OPD_NIBS + i];
      end
   end

   logic [2*W-1:0] a_ext;
   logic [2*W-1:0] b_ext;
   logic [W:0]     add_sum;
   logic [W-1:0]   sub_diff;
   logic [W-1:0]   sh_amt;
   logic [W-1:0]   shl_val;
   logic [W-1:0]   shr_val;
   logic [2*W-1:0] alu_res;
   logic           alu_flag;
   logic           alu_err;

   // Narrow ops produce W bits and are zero-extended into the 2W result
   always_comb begin
      a_ext    = {{W{1'b0}}, opd_a};
      b_ext    = {{W{1'b0}}, opd_b};
      add_sum  = {1'b0, opd_a} + {1'b0, opd_b};
      sub_diff = opd_a - opd_b;
      sh_amt   = W'(opd_b % W);
      shl_val  = opd_a << sh_amt;
      shr_val  = opd_a >> sh_amt;
      alu_res  = '0;
      alu_flag = 1'b0;
      alu_err  = 1'b0;
      case (opcode)
         NIB_W'(0): begin
            alu_res  = {{(W-1){1'b0}}, add_sum};
            alu_flag = add_sum[W];
         end
         NIB_W'(1): begin
            alu_res  = {{W{1'b0}}, sub_diff};
            alu_flag = opd_a < opd_b;
         end
         NIB_W'(2): alu_res = a_ext * b_ext;
         NIB_W'(3): alu_res = {{W{1'b0}}, opd_a & opd_b};
         NIB_W'(4): alu_res = {{W{1'b0}}, opd_a | opd_b};
         NIB_W'(5): alu_res = {{W{1'b0}}, opd_a ^ opd_b};
         NIB_W'(6): alu_res = {{W{1'b0}}, shl_val};
         NIB_W'(7): alu_res = {{W{1'b0}}, shr_val};
         NIB_W'(8): alu_res = (a_ext > b_ext) ? a_ext : b_ext;
         NIB_W'(9): alu_res = (a_ext < b_ext) ? a_ext : b_ext;
         default:   alu_err = 1'b1;
      endcase
   end

   // enp is tested before bkp in every state, so a simultaneous back is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         idx          <= '0;
         result       <= '0;
         flag         <= 1'b0;
         err          <= 1'b0;
         result_valid <= 1'b0;
         for (int i = 0; i < N; i++) entries[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (enp) begin
                  state <= S_ENTRY;
                  idx   <= '0;
               end
            end
            S_ENTRY: begin
               if (enp) begin
                  for (int i = 0; i < N; i++)
                     if (idx == IDX_W'(i)) entries[i] <= bus.sw;
                  idx <= idx + 1'b1;
                  if (idx == IDX_W'(N - 1)) state <= S_CALC;
               end else if (bkp) begin
                  if (idx != '0) begin
                     for (int i = 0; i < N - 1; i++)
                        if (idx == IDX_W'(i + 1)) entries[i] <= '0;
                     idx <= idx - 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_CALC: begin
               result       <= alu_res;
               flag         <= alu_flag;
               err          <= alu_err;
               result_valid <= 1'b1;
               state        <= S_DONE;
            end
            S_DONE: begin
               if (enp) begin
                  state        <= S_IDLE;
                  idx          <= '0;
                  result_valid <= 1'b0;
                  for (int i = 0; i < N; i++) entries[i] <= '0;
               end else if (bkp) begin
                  state        <= S_ENTRY;
                  idx          <= IDX_W'(N - 1);
                  result_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   logic [NIB_W-1:0] last_nib;
   logic [6:0]       seg_hi_c;
   logic [6:0]       seg_lo_c;

   // Digits are pure decodes of registered state, so reset blanks them at once
   always_comb begin
      last_nib = '0;
      for (int i = 1; i < N; i++)
         if (idx == IDX_W'(i)) last_nib = entries[i - 1];
      seg_hi_c = 7'h7F;
      seg_lo_c = 7'h7F;
      case (state)
         S_ENTRY: begin
            seg_hi_c = hex7(4'(idx));
            if (idx != '0) seg_lo_c = hex7(4'(last_nib));
         end
         S_DONE: begin
            seg_hi_c = hex7(result[7:4]);
            seg_lo_c = hex7(result[3:0]);
         end
         default: ;
      endcase
   end

   assign bus.result       = result;
   assign bus.result_valid = result_valid;
   assign bus.flag         = flag;
   assign bus.err          = err;
   assign bus.entry_idx    = idx;
   assign bus.led          = {flag | err, state == S_DONE,
                              (state == S_ENTRY) || (state == S_CALC),
                              state == S_IDLE};
   assign bus.seg_hi       = seg_hi_c;
   assign bus.seg_lo       = seg_lo_c;
endmodule

// File: tb/tb_mpu_entry_calc.sv
// Randomised and directed bench for mpu_entry_calc with an integer-arithmetic
// reference model of the ALU and the display decode.
module tb_mpu_entry_calc;
   localparam int NIB_W    = 4;
   localparam int OPD_NIBS = 2;
   localparam int SYNC_STG = 2;
   localparam int W        = NIB_W * OPD_NIBS;
   localparam int N        = 1 + 2 * OPD_NIBS;
   localparam int IDX_W    = $clog2(N);

   localparam logic [6:0] SEG_LIT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   mpu_entry_calc_if #(.NIB_W(NIB_W), .OPD_NIBS(OPD_NIBS)) bus ();

   mpu_entry_calc #(.NIB_W(NIB_W), .OPD_NIBS(OPD_NIBS), .SYNC_STG(SYNC_STG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int v);
      return ~SEG_LIT[v & 15];
   endfunction

   function automatic int nib_at(input int op, input int a, input int b, input int i);
      if (i == 0) return op & ((1 << NIB_W) - 1);
      if (i <= OPD_NIBS) return (a >> ((OPD_NIBS - i) * NIB_W)) & ((1 << NIB_W) - 1);
      return (b >> ((2 * OPD_NIBS - i) * NIB_W)) & ((1 << NIB_W) - 1);
   endfunction

   // Reference ALU on plain integers
   task automatic model(input int op, input int a, input int b,
                        output int r, output bit f, output bit e);
      int m;
      m = 1 << W;
      f = 1'b0;
      e = 1'b0;
      r = 0;
      case (op)
         0: begin r = a + b; f = (a + b) >= m; end
         1: begin r = (a - b + m) % m; f = a < b; end
         2: r = a * b;
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = (a << (b % W)) % m;
         7: r = a >> (b % W);
         8: r = (a > b) ? a : b;
         9: r = (a < b) ? a : b;
         default: e = 1'b1;
      endcase
   endtask

   // Drive buttons for hold cycles, release, then let the FSM settle
   task automatic press(input bit en, input bit bk, input int hold);
      @(negedge clk);
      bus.btn_enter = en;
      bus.btn_back  = bk;
      repeat (hold) @(negedge clk);
      bus.btn_enter = 1'b0;
      bus.btn_back  = 1'b0;
      repeat (SYNC_STG + 4) @(negedge clk);
   endtask

   task automatic enter_prefix(input int op, input int a, input int b, input int cnt);
      press(1'b1, 1'b0, 1);
      for (int i = 0; i < cnt; i++) begin
         bus.sw = NIB_W'(nib_at(op, a, b, i));
         press(1'b1, 1'b0, 1);
      end
   endtask

   task automatic test_reset();
      checks++; if (bus.result !== '0) begin failures++; $display("[TB] FAIL reset_result: got %h want 0", bus.result); end
      checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", bus.result_valid); end
      checks++; if (bus.flag !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags: got flag=%b err=%b want 0/0", bus.flag, bus.err); end
      checks++; if (bus.entry_idx !== '0) begin failures++; $display("[TB] FAIL reset_idx: got %0d want 0", bus.entry_idx); end
      checks++; if (bus.led !== 4'b0001) begin failures++; $display("[TB] FAIL reset_led: got %b want 0001", bus.led); end
      checks++; if (bus.seg_hi !== 7'h7F || bus.seg_lo !== 7'h7F) begin failures++; $display("[TB] FAIL reset_seg: got %h/%h want 7f/7f", bus.seg_hi, bus.seg_lo); end
   endtask

   task automatic test_add_latency();
      enter_prefix(0, 'hA5, 'h5B, N - 1);
      bus.sw = NIB_W'(nib_at(0, 'hA5, 'h5B, N - 1));
      @(negedge clk);
      bus.btn_enter = 1'b1;
      for (int e = 1; e <= SYNC_STG + 2; e++) begin
         @(posedge clk);
         #1;
         if (e == SYNC_STG + 1) begin
            checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_latency_early: got %b want 0", bus.result_valid); end
         end
         if (e == SYNC_STG + 2) begin
            checks++; if (bus.result_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_latency_rise: got %b want 1", bus.result_valid); end
         end
      end
      @(negedge clk);
      bus.btn_enter = 1'b0;
      repeat (SYNC_STG + 4) @(negedge clk);
      checks++; if (bus.result !== 16'h0100) begin failures++; $display("[TB] FAIL add_result: got %h want 0100", bus.result); end
      checks++; if (bus.flag !== 1'b1 || bus.err !== 1'b0) begin failures++; $display("[TB] FAIL add_flags: got flag=%b err=%b want 1/0", bus.flag, bus.err); end
      checks++; if (bus.led !== 4'b1100) begin failures++; $display("[TB] FAIL add_led: got %b want 1100", bus.led); end
      checks++; if (bus.seg_hi !== seg_of(0) || bus.seg_lo !== seg_of(0)) begin failures++; $display("[TB] FAIL add_seg: got %h/%h want %h/%h", bus.seg_hi, bus.seg_lo, seg_of(0), seg_of(0)); end
      press(1'b1, 1'b0, 1);
   endtask

   task automatic test_mul_done_exit();
      enter_prefix(2, 'hFF, 'hFF, N);
      checks++; if (bus.result !== 16'hFE01 || bus.flag !== 1'b0) begin failures++; $display("[TB] FAIL mul_result: got %h flag=%b want fe01 flag=0", bus.result, bus.flag); end
      checks++; if (bus.seg_hi !== seg_of(0) || bus.seg_lo !== seg_of(1)) begin failures++; $display("[TB] FAIL mul_seg: got %h/%h want %h/%h", bus.seg_hi, bus.seg_lo, seg_of(0), seg_of(1)); end
      press(1'b1, 1'b0, 1);
      checks++; if (bus.led !== 4'b0001 || bus.result_valid !== 1'b0) begin failures++; $display("[TB] FAIL mul_exit_led: got led=%b valid=%b want 0001/0", bus.led, bus.result_valid); end
      checks++; if (bus.result !== 16'hFE01) begin failures++; $display("[TB] FAIL mul_exit_hold: got %h want fe01", bus.result); end
      checks++; if (bus.seg_hi !== 7'h7F || bus.seg_lo !== 7'h7F) begin failures++; $display("[TB] FAIL mul_exit_seg: got %h/%h want 7f/7f", bus.seg_hi, bus.seg_lo); end
   endtask

   task automatic test_sub();
      enter_prefix(1, 'h03, 'h05, N);
      checks++; if (bus.result !== 16'h00FE || bus.flag !== 1'b1) begin failures++; $display("[TB] FAIL sub_borrow: got %h flag=%b want 00fe flag=1", bus.result, bus.flag); end
      press(1'b1, 1'b0, 1);
      enter_prefix(1, 'h05, 'h03, N);
      checks++; if (bus.result !== 16'h0002 || bus.flag !== 1'b0) begin failures++; $display("[TB] FAIL sub_plain: got %h flag=%b want 0002 flag=0", bus.result, bus.flag); end
      press(1'b1, 1'b0, 1);
   endtask

   task automatic test_back_out();
      press(1'b1, 1'b0, 1);
      checks++; if (bus.led[2:0] !== 3'b010 || bus.entry_idx !== '0) begin failures++; $display("[TB] FAIL back_enter: got led=%b idx=%0d want x010 idx=0", bus.led, bus.entry_idx); end
      checks++; if (bus.seg_hi !== seg_of(0) || bus.seg_lo !== 7'h7F) begin failures++; $display("[TB] FAIL back_seg0: got %h/%h want %h/7f", bus.seg_hi, bus.seg_lo, seg_of(0)); end
      bus.sw = '0;
      press(1'b1, 1'b0, 1);
      checks++; if (bus.entry_idx !== IDX_W'(1) || bus.seg_hi !== seg_of(1) || bus.seg_lo !== seg_of(0)) begin failures++; $display("[TB] FAIL back_idx1: got idx=%0d seg=%h/%h want 1 %h/%h", bus.entry_idx, bus.seg_hi, bus.seg_lo, seg_of(1), seg_of(0)); end
      press(1'b0, 1'b1, 1);
      checks++; if (bus.entry_idx !== '0 || bus.seg_lo !== 7'h7F || bus.led[2:0] !== 3'b010) begin failures++; $display("[TB] FAIL back_undo: got idx=%0d seg_lo=%h led=%b want 0 7f x010", bus.entry_idx, bus.seg_lo, bus.led); end
      press(1'b0, 1'b1, 1);
      checks++; if (bus.led[2:0] !== 3'b001 || bus.seg_hi !== 7'h7F) begin failures++; $display("[TB] FAIL back_idle: got led=%b seg_hi=%h want x001 7f", bus.led, bus.seg_hi); end
      press(1'b0, 1'b1, 1);
      checks++; if (bus.led[2:0] !== 3'b001) begin failures++; $display("[TB] FAIL back_idle_ignore: got led=%b want x001", bus.led); end
   endtask

   task automatic test_done_edit();
      int exp_r [2];
      exp_r[0] = 'h0030;
      exp_r[1] = 'h00FF;
      for (int k = 0; k < 2; k++) begin
         enter_prefix(3 + k, 'hF0, 'h3C, N);
         checks++; if (bus.result !== 16'((k == 0) ? 'h30 : 'hFC)) begin failures++; $display("[TB] FAIL edit_first_op%0d: got %h", 3 + k, bus.result); end
         press(1'b0, 1'b1, 1);
         checks++; if (bus.entry_idx !== IDX_W'(N - 1) || bus.result_valid !== 1'b0 || bus.led[2:0] !== 3'b010) begin failures++; $display("[TB] FAIL edit_back: got idx=%0d valid=%b led=%b want %0d 0 x010", bus.entry_idx, bus.result_valid, bus.led, N - 1); end
         checks++; if (bus.seg_hi !== seg_of(N - 1) || bus.seg_lo !== seg_of(3)) begin failures++; $display("[TB] FAIL edit_seg: got %h/%h want %h/%h", bus.seg_hi, bus.seg_lo, seg_of(N - 1), seg_of(3)); end
         bus.sw = NIB_W'(4'hF);
         press(1'b1, 1'b0, 1);
         checks++; if (bus.result !== 16'(exp_r[k]) || bus.result_valid !== 1'b1) begin failures++; $display("[TB] FAIL edit_result_op%0d: got %h valid=%b want %h 1", 3 + k, bus.result, bus.result_valid, 16'(exp_r[k])); end
         press(1'b1, 1'b0, 1);
      end
   endtask

   task automatic test_bad_opcode();
      int a = $urandom_range(0, (1 << W) - 1);
      int b = $urandom_range(0, (1 << W) - 1);
      enter_prefix('hC, a, b, N);
      checks++; if (bus.result !== '0 || bus.err !== 1'b1 || bus.flag !== 1'b0) begin failures++; $display("[TB] FAIL badop: got %h err=%b flag=%b want 0 1 0", bus.result, bus.err, bus.flag); end
      checks++; if (bus.led !== 4'b1100) begin failures++; $display("[TB] FAIL badop_led: got %b want 1100", bus.led); end
      press(1'b1, 1'b1, 10);
      checks++; if (bus.led !== 4'b1001 || bus.result_valid !== 1'b0) begin failures++; $display("[TB] FAIL both_buttons: got led=%b valid=%b want 1001 0", bus.led, bus.result_valid); end
   endtask

   task automatic test_random();
      int op, a, b, r;
      bit f, e;
      for (int t = 0; t < 24; t++) begin
         op = $urandom_range(0, 15);
         a  = $urandom_range(0, (1 << W) - 1);
         b  = $urandom_range(0, (1 << W) - 1);
         model(op, a, b, r, f, e);
         enter_prefix(op, a, b, N);
         checks++; if (bus.result !== 16'(r) || bus.flag !== f || bus.err !== e || bus.result_valid !== 1'b1) begin failures++; $display("[TB] FAIL rand_op%0d a=%h b=%h: got %h f=%b e=%b v=%b want %h f=%b e=%b v=1", op, a, b, bus.result, bus.flag, bus.err, bus.result_valid, 16'(r), f, e); end
         checks++; if (bus.led !== {f | e, 3'b100} || bus.seg_hi !== seg_of(r >> 4) || bus.seg_lo !== seg_of(r)) begin failures++; $display("[TB] FAIL rand_disp_op%0d: got led=%b seg=%h/%h want %b %h/%h", op, bus.led, bus.seg_hi, bus.seg_lo, {f | e, 3'b100}, seg_of(r >> 4), seg_of(r)); end
         press(1'b1, 1'b0, 1);
      end
   endtask

   task automatic test_reset_mid_op();
      enter_prefix(2, 'h12, 'h34, 3);
      checks++; if (bus.entry_idx !== IDX_W'(3)) begin failures++; $display("[TB] FAIL midop_idx: got %0d want 3", bus.entry_idx); end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.result !== '0 || bus.entry_idx !== '0 || bus.led !== 4'b0001) begin failures++; $display("[TB] FAIL async_reset: got res=%h idx=%0d led=%b want 0 0 0001", bus.result, bus.entry_idx, bus.led); end
      checks++; if (bus.seg_hi !== 7'h7F || bus.seg_lo !== 7'h7F || bus.flag !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_disp: got seg=%h/%h flag=%b err=%b", bus.seg_hi, bus.seg_lo, bus.flag, bus.err); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_held_enter();
      press(1'b1, 1'b0, 50);
      checks++; if (bus.led !== 4'b0010 || bus.entry_idx !== '0) begin failures++; $display("[TB] FAIL held_enter: got led=%b idx=%0d want 0010 0", bus.led, bus.entry_idx); end
      press(1'b0, 1'b1, 1);
      checks++; if (bus.led !== 4'b0001) begin failures++; $display("[TB] FAIL held_exit: got led=%b want 0001", bus.led); end
   endtask

   initial begin
      bus.sw        = '0;
      bus.btn_enter = 1'b0;
      bus.btn_back  = 1'b0;
      rst           = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      test_add_latency();
      test_mul_done_exit();
      test_sub();
      test_back_out();
      test_done_edit();
      test_bad_opcode();
      test_random();
      test_reset_mid_op();
      test_held_enter();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
